// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin sharing of one pipelined multiplier, with requester-ID return and drain control
// Optional counters: define MULT_SHARE_ARB_STATS_EN to add stat_issue / stat_conflict.

module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 64,
  parameter int BW   = 64,
  parameter int LAT  = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_a,
  input  logic [NREQ*BW-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 drain_req,
  output logic                 drained,
  output logic                 mult_rst_n,
  output logic [AW-1:0]        mult_a,
  output logic [BW-1:0]        mult_b,
  input  logic [AW+BW-1:0]     mult_c,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [AW+BW-1:0]     rsp_data
`ifdef MULT_SHARE_ARB_STATS_EN
  ,
  output logic [31:0]          stat_issue,
  output logic [31:0]          stat_conflict
`endif
);

  // One spare bit so ptr + offset never overflows before the modulo wrap.
  localparam int CW = IDW + 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]      mult_a_q, mult_a_d;
  logic [BW-1:0]      mult_b_q, mult_b_d;

  // Tag stage 0 is loaded together with the operand registers; stages 1..LAT
  // track the multiplier's internal registers, so stage LAT lines up with mult_c.
  logic [LAT:0]       tag_vld_q, tag_vld_d;
  logic [IDW-1:0]     tag_id_q [0:LAT];

  logic               issue_en;
  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [CW-1:0]      cand;
  logic               xfer;
  logic               tag_busy;
  logic [AW-1:0]      a_sel;
  logic [BW-1:0]      b_sel;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: drain stops issue, waits for empty tags, resumes when drain_req drops
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (drain_req)  state_d = ST_DRAIN;
      ST_DRAIN:   if (!tag_busy)  state_d = ST_DRAINED;
      ST_DRAINED: if (!drain_req) state_d = ST_RUN;
      default:                    state_d = ST_RUN;
    endcase
  end

  // FSM outputs: grants only in RUN with no drain request; reset forces them off
  always_comb begin
    issue_en = (state_q == ST_RUN) && !drain_req && !rst;
    drained  = (state_q == ST_DRAINED);
  end

  // Round-robin search starting one past the last winner, wrapping modulo NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = {1'b0, ptr_q} + CW'(off);
      if (cand >= CW'(NREQ)) begin
        cand = cand - CW'(NREQ);
      end
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // One-hot grant vector and the resulting transfer strobe
  always_comb begin
    req_ready = '0;
    if (issue_en && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
    xfer = issue_en && grant_found;
  end

  // Operand mux for the winning requester
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        a_sel = req_a[i*AW +: AW];
        b_sel = req_b[i*BW +: BW];
      end
    end
  end

  // Next-state for pointer, operand registers and tag valid shift
  always_comb begin
    ptr_d     = xfer ? grant_idx : ptr_q;
    mult_a_d  = xfer ? a_sel : mult_a_q;
    mult_b_d  = xfer ? b_sel : mult_b_q;
    tag_vld_d = {tag_vld_q[LAT-1:0], xfer};
  end

  // Pointer and operand registers; operands hold when nothing is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= IDW'(NREQ - 1);
      mult_a_q <= '0;
      mult_b_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
    end
  end

  // Tag shift pipeline; an idle slot carries ID 0 so rsp_id is 0 when nothing returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int j = 0; j <= LAT; j++) begin
        tag_id_q[j] <= '0;
      end
    end else begin
      tag_vld_q   <= tag_vld_d;
      tag_id_q[0] <= xfer ? grant_idx : '0;
      for (int j = 1; j <= LAT; j++) begin
        tag_id_q[j] <= tag_id_q[j-1];
      end
    end
  end

  assign tag_busy   = |tag_vld_q;
  assign mult_rst_n = ~rst;
  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign rsp_valid  = tag_vld_q[LAT];
  assign rsp_id     = tag_id_q[LAT];
  assign rsp_data   = mult_c;

`ifdef MULT_SHARE_ARB_STATS_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic        multi_req;

  // Saturating counters: transfers, and RUN cycles with two or more requesters pending
  always_comb begin
    multi_req      = |(req_valid & (req_valid - NREQ'(1)));
    issue_cnt_d    = issue_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (xfer && (issue_cnt_q != 32'hFFFF_FFFF)) begin
      issue_cnt_d = issue_cnt_q + 32'd1;
    end
    if ((state_q == ST_RUN) && multi_req && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      issue_cnt_q    <= issue_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign stat_issue    = issue_cnt_q;
  assign stat_conflict = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - randomized bench for mult_share_arb against a behavioural model

`timescale 1ns/1ps

module tb_mult_share_arb;

  localparam int NREQ = 4;
  localparam int AW   = 64;
  localparam int BW   = 64;
  localparam int LAT  = 3;
  localparam int IDW  = 2;
  localparam int PW   = AW + BW;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_a;
  logic [NREQ*BW-1:0]  req_b;
  logic [NREQ-1:0]     req_ready;
  logic                drain_req;
  logic                drained;
  logic                mult_rst_n;
  logic [AW-1:0]       mult_a;
  logic [BW-1:0]       mult_b;
  logic [PW-1:0]       mult_c;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [PW-1:0]       rsp_data;
`ifdef MULT_SHARE_ARB_STATS_EN
  logic [31:0]         stat_issue;
  logic [31:0]         stat_conflict;
`endif

  always #5 clk = ~clk;

  mult_share_arb #(.NREQ(NREQ), .AW(AW), .BW(BW), .LAT(LAT), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .drain_req  (drain_req),
    .drained    (drained),
    .mult_rst_n (mult_rst_n),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_c     (mult_c),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
`ifdef MULT_SHARE_ARB_STATS_EN
    ,.stat_issue    (stat_issue)
    ,.stat_conflict (stat_conflict)
`endif
  );

  // Shared multiplier: LAT registers, asynchronous active-low reset
  logic [PW-1:0] mpipe [1:LAT];
  always_ff @(posedge clk or negedge mult_rst_n) begin
    if (!mult_rst_n) begin
      for (int j = 1; j <= LAT; j++) mpipe[j] <= '0;
    end else begin
      mpipe[1] <= PW'(mult_a) * PW'(mult_b);
      for (int j = 2; j <= LAT; j++) mpipe[j] <= mpipe[j-1];
    end
  end
  assign mult_c = mpipe[LAT];

  typedef struct { int due; int id; logic [PW-1:0] prod; } exp_t;
  typedef struct { int cyc; int id; logic [PW-1:0] data; } ev_t;

  exp_t          q[$];
  ev_t           glog[$];
  ev_t           rlog[$];
  int            m_ptr, m_state, m_issue, m_conf;
  logic [AW-1:0] m_a;
  logic [BW-1:0] m_b;
  int            cyc;
  int            drained_first;
  int            n_pass = 0;
  int            n_total = 0;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int off = 1; off <= NREQ; off++) begin
      if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr   = NREQ - 1;
    m_state = 0;
    m_a     = '0;
    m_b     = '0;
    m_issue = 0;
    m_conf  = 0;
  endtask

  // Compare DUT against the model for the current cycle, then advance the model over the next edge
  task automatic cycle_check();
    int              g;
    bit              busy;
    logic [NREQ-1:0] exp_rdy;
    exp_t            e;
    ev_t             ev;
    #1;
    chk("mult_rst_n", mult_rst_n, !rst);
    if (rst) begin
      model_reset();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_drained", drained, 0);
      chk("rst_mult_a", mult_a, 0);
      chk("rst_mult_b", mult_b, 0);
`ifdef MULT_SHARE_ARB_STATS_EN
      chk("rst_stat_issue", stat_issue, 0);
      chk("rst_stat_conflict", stat_conflict, 0);
`endif
      return;
    end
    g = -1;
    if (m_state == 0 && !drain_req) g = rr_pick(req_valid, m_ptr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("drained", drained, m_state == 2);
    chk("mult_a", mult_a, m_a);
    chk("mult_b", mult_b, m_b);
    busy = (q.size() != 0);
    if (busy && q[0].due == cyc) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_data", rsp_data, q[0].prod);
      void'(q.pop_front());
    end else begin
      chk("rsp_valid_idle", rsp_valid, 0);
    end
`ifdef MULT_SHARE_ARB_STATS_EN
    chk("stat_issue", stat_issue, m_issue);
    chk("stat_conflict", stat_conflict, m_conf);
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        ev.cyc = cyc; ev.id = i; ev.data = '0;
        glog.push_back(ev);
      end
    end
    if (rsp_valid) begin
      ev.cyc = cyc; ev.id = int'(rsp_id); ev.data = rsp_data;
      rlog.push_back(ev);
    end
    if (drained && drained_first < 0) drained_first = cyc;
    if (g >= 0) begin
      e.due  = cyc + 1 + LAT;
      e.id   = g;
      e.prod = PW'(req_a[g*AW +: AW]) * PW'(req_b[g*BW +: BW]);
      q.push_back(e);
      m_ptr = g;
      m_a   = req_a[g*AW +: AW];
      m_b   = req_b[g*BW +: BW];
      m_issue++;
    end
    if (m_state == 0 && $countones(req_valid) >= 2) m_conf++;
    case (m_state)
      0: if (drain_req) m_state = 1;
      1: if (!busy) m_state = 2;
      default: if (!drain_req) m_state = 0;
    endcase
  endtask

  task automatic step();
    cycle_check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_ops(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_a[i*AW +: AW] = a;
    req_b[i*BW +: BW] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      if ($urandom_range(0, 9) == 0) set_ops(i, '1, '1);
      else set_ops(i, {$urandom, $urandom}, {$urandom, $urandom});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs, dc;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; drain_req = 1'b0;
    cyc = 0; drained_first = -1;
    model_reset();
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    step();

    // Single requester 2, all-ones times two
    glog.delete(); rlog.delete();
    req_valid = 4'b0100;
    set_ops(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    hs = cyc;
    step();
    req_valid = '0;
    repeat (6) step();
    chk("lit_b_grants", glog.size(), 1);
    chk("lit_b_rsps", rlog.size(), 1);
    if (rlog.size() == 1) begin
      chk("lit_b_latency", rlog[0].cyc - hs, 4);
      chk("lit_b_id", rlog[0].id, 2);
      chk("lit_b_data", rlog[0].data, 128'h1_FFFF_FFFF_FFFF_FFFE);
    end

    // All four valid right after reset: strict rotation
    rst = 1'b1; step(); rst = 1'b0;
    glog.delete(); rlog.delete();
    req_valid = '1;
    repeat (8) begin rand_ops(); step(); end
    req_valid = '0;
    repeat (6) step();
    chk("lit_c_grants", glog.size(), 8);
    chk("lit_c_rsps", rlog.size(), 8);
    if (glog.size() == 8 && rlog.size() == 8) begin
      chk("lit_c_first_lat", rlog[0].cyc - glog[0].cyc, LAT + 1);
      for (int i = 0; i < 8; i++) begin
        chk("lit_c_grant_order", glog[i].id, i % 4);
        chk("lit_c_rsp_order", rlog[i].id, i % 4);
        chk("lit_c_rsp_consec", rlog[i].cyc - rlog[0].cyc, i);
      end
    end

    // Requesters 1 and 3 with ptr = 1
    glog.delete();
    req_valid = 4'b0010; rand_ops(); step();
    req_valid = 4'b1010;
    repeat (4) begin rand_ops(); step(); end
    req_valid = '0;
    repeat (6) step();
    chk("lit_d_grants", glog.size(), 5);
    if (glog.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("lit_d_order", glog[i].id, (i % 2 == 0) ? 1 : 3);
    end

    // Drain with two products in flight
    glog.delete(); rlog.delete(); drained_first = -1;
    req_valid = 4'b0001;
    rand_ops(); step();
    rand_ops(); step();
    drain_req = 1'b1;
    req_valid = '1;
    repeat (8) step();
    chk("lit_e_grants", glog.size(), 2);
    chk("lit_e_rsps", rlog.size(), 2);
    if (rlog.size() == 2) chk("lit_e_drained_time", drained_first - rlog[1].cyc, 2);
    drain_req = 1'b0;
    dc = cyc;
    repeat (3) step();
    req_valid = '0;
    repeat (6) step();
    chk("lit_e_resume_grants", glog.size() >= 3, 1);
    if (glog.size() >= 3) chk("lit_e_resume_cycle", glog[2].cyc - dc, 1);

    // Reset with three products in flight
    rlog.delete();
    req_valid = 4'b0001;
    repeat (3) begin rand_ops(); step(); end
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("lit_f_mult_rst_n", mult_rst_n, 0);
    chk("lit_f_mult_a", mult_a, 0);
    chk("lit_f_mult_b", mult_b, 0);
    chk("lit_f_drained", drained, 0);
    step();
    rst = 1'b0;
    repeat (8) step();
    chk("lit_f_no_rsp", rlog.size(), 0);

`ifdef MULT_SHARE_ARB_STATS_EN
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = '1;
    repeat (4) begin rand_ops(); step(); end
    req_valid = 4'b0001;
    repeat (6) begin rand_ops(); step(); end
    req_valid = '0;
    #1;
    chk("lit_g_issue", stat_issue, 10);
    chk("lit_g_conflict", stat_conflict, 4);
    rst = 1'b1;
    #1;
    chk("lit_g_issue_clr", stat_issue, 0);
    chk("lit_g_conflict_clr", stat_conflict, 0);
    step();
    rst = 1'b0;
`endif

    // Randomized traffic with drain and reset events
    repeat (1500) begin
      case ($urandom_range(0, 3))
        0: req_valid = NREQ'($urandom);
        1: req_valid = NREQ'(1) << $urandom_range(0, NREQ - 1);
        2: req_valid = '1;
        default: req_valid = '0;
      endcase
      if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
      rst = ($urandom_range(0, 249) == 0);
      rand_ops();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
